uart_rx_frame_ctrl: RTL and testbench

Receive-side frame controller that sits directly behind the UART receiver. It consumes the receiver's byte stream (done pulse plus byte), hunts for a sync byte and parses length-prefixed frames into an internal payload buffer. It checks an XOR checksum and releases only verified payloads to a valid/ready byte stream. It also flags length, checksum, inter-byte-timeout and overrun errors, with the timeout measured in oversampling ticks.

---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/uart_frame_buf.sv | 36 +++
 rtl/uart_rx_frame_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART receive-side frame controller.
//   frame_state_e     : parser/drain FSM states
//   ERR_*             : err_code values reported alongside frame_err
//   SYNC_BYTE_DEFAULT : default frame start marker
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHK,
        DRAIN
    } frame_state_e;

    localparam logic [1:0] ERR_LEN = 2'b01;
    localparam logic [1:0] ERR_CHK = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x DBIT register file, one synchronous write port
// and one asynchronous read port.
//   clk    : system clock
//   we     : write enable for wdata at wr_ptr
//   wr_ptr : write address
//   wdata  : write data
//   rd_ptr : read address
//   rdata  : combinational read data at rd_ptr
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int MAX_LEN = 16,
    parameter int AW      = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   wr_ptr,
    input  logic [DBIT-1:0] wdata,
    input  logic [AW-1:0]   rd_ptr,
    output logic [DBIT-1:0] rdata
);

    // Payload storage needs no reset: a byte is only read back after it
    // has been written within the same frame.
    logic [DBIT-1:0] mem_q [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver. Hunts for SYNC_BYTE, parses
// SYNC, LEN, LEN payload bytes, CHK (CHK = LEN ^ payload bytes), buffers the
// payload and releases verified payloads as a valid/ready byte stream.
//   clk, reset_n     : clock, asynchronous active-low reset
//   rx_done_tick     : receiver byte strobe, rx_dout valid this cycle
//   rx_dout          : received byte
//   s_tick           : oversampling tick, used for the inter-byte timeout
//   pkt_data/valid/ready/last : payload byte stream
//   frame_ok         : pulse, frame verified, drain starts this cycle
//   frame_err        : pulse, frame discarded; cause in err_code
//   err_code         : 01 length, 10 checksum, 11 timeout; holds otherwise
//   rx_overrun       : pulse, byte dropped while draining
//   busy             : high whenever the FSM is not in IDLE
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int              DBIT          = 8,
    parameter int              MAX_LEN       = 16,
    parameter logic [DBIT-1:0] SYNC_BYTE     = DBIT'(SYNC_BYTE_DEFAULT),
    parameter int              TIMEOUT_TICKS = 2560
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx_done_tick,
    input  logic [DBIT-1:0] rx_dout,
    input  logic            s_tick,
    output logic [DBIT-1:0] pkt_data,
    output logic            pkt_valid,
    input  logic            pkt_ready,
    output logic            pkt_last,
    output logic            frame_ok,
    output logic            frame_err,
    output logic [1:0]      err_code,
    output logic            rx_overrun,
    output logic            busy
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_TICKS);

    frame_state_e    state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DBIT-1:0] chk_q, chk_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            rx_overrun_q, rx_overrun_d;

    logic            buf_we;
    logic [DBIT-1:0] buf_rdata;
    logic            in_frame;
    logic            len_bad;
    logic            last_beat;

    uart_frame_buf #(
        .DBIT    (DBIT),
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk    (clk),
        .we     (buf_we),
        .wr_ptr (wr_ptr_q[AW-1:0]),
        .wdata  (rx_dout),
        .rd_ptr (rd_ptr_q[AW-1:0]),
        .rdata  (buf_rdata)
    );

    assign in_frame  = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
    assign len_bad   = (rx_dout == '0) || (32'(rx_dout) > 32'(MAX_LEN));
    assign last_beat = (rd_ptr_q == len_q - 1'b1);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        chk_d        = chk_q;
        tmo_d        = tmo_q;
        pkt_valid_d  = pkt_valid_q;
        err_code_d   = err_code_q;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
        rx_overrun_d = 1'b0;
        buf_we       = 1'b0;

        // Inter-byte timeout: a byte in the same cycle as the terminal tick
        // wins, so the counter only advances on ticks without a byte.
        if (in_frame) begin
            if (rx_done_tick) begin
                tmo_d = '0;
            end else if (s_tick && (tmo_q != TMO_MAX)) begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (rx_done_tick && (rx_dout == SYNC_BYTE)) begin
                    state_d  = LEN;
                    tmo_d    = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            LEN: begin
                if (rx_done_tick) begin
                    if (len_bad) begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end else begin
                        state_d = PAYLOAD;
                        len_d   = rx_dout[LW-1:0];
                        chk_d   = rx_dout;
                    end
                end
            end
            PAYLOAD: begin
                // SYNC_BYTE is ordinary data here.
                if (rx_done_tick) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    chk_d    = chk_q ^ rx_dout;
                    if (wr_ptr_q == len_q - 1'b1) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (rx_done_tick) begin
                    if (rx_dout == chk_q) begin
                        state_d     = DRAIN;
                        frame_ok_d  = 1'b1;
                        pkt_valid_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                end
            end
            DRAIN: begin
                // Receiver cannot be stalled: bytes arriving now are lost.
                if (rx_done_tick) begin
                    rx_overrun_d = 1'b1;
                end
                // Valid/ready: a byte moves on every cycle where pkt_valid
                // and pkt_ready are both high; pkt_valid never depends on
                // pkt_ready, and pkt_data/pkt_last hold until the transfer.
                if (pkt_valid_q && pkt_ready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (last_beat) begin
                        pkt_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (in_frame && !rx_done_tick && s_tick && (tmo_q == TMO_LAST)) begin
            state_d     = IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TMO;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            chk_q        <= '0;
            tmo_q        <= '0;
            pkt_valid_q  <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            chk_q        <= chk_d;
            tmo_q        <= tmo_d;
            pkt_valid_q  <= pkt_valid_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    // Gating keeps the stream outputs at zero outside a drain.
    assign pkt_data   = pkt_valid_q ? buf_rdata : '0;
    assign pkt_valid  = pkt_valid_q;
    assign pkt_last   = pkt_valid_q && last_beat;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign rx_overrun = rx_overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 2560;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_dout = 8'h00;
    logic       s_tick = 1'b0;
    logic       pkt_ready = 1'b1;
    logic [7:0] pkt_data;
    logic       pkt_valid, pkt_last, frame_ok, frame_err, rx_overrun, busy;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(
        .DBIT(8), .MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT_TICKS(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rx_done_tick(rx_done_tick),
        .rx_dout(rx_dout), .s_tick(s_tick), .pkt_data(pkt_data),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_last(pkt_last),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
        .rx_overrun(rx_overrun), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // phase: 0 hunting, 1 expecting length, 2 collecting payload,
    // 3 expecting checksum, 4 delivering verified payload
    int         m_phase = 0;
    int         m_len = 0;
    int         m_ticks = 0;
    logic [7:0] m_frame[$];
    logic [7:0] m_out[$];
    logic [7:0] m_x;
    logic       e_ok = 1'b0, e_err = 1'b0, e_ovr = 1'b0;
    logic [1:0] e_code = 2'b00;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_phase = 0; m_len = 0; m_ticks = 0;
            m_frame.delete(); m_out.delete();
            e_ok = 0; e_err = 0; e_ovr = 0; e_code = 0;
        end else begin
            e_ok = 0; e_err = 0; e_ovr = 0;
            case (m_phase)
                0: if (rx_done_tick && rx_dout == 8'hA5) begin
                    m_phase = 1; m_ticks = 0; m_frame.delete();
                end
                1, 2, 3: begin
                    if (rx_done_tick) begin
                        m_ticks = 0;
                        if (m_phase == 1) begin
                            if (rx_dout == 0 || int'(rx_dout) > MAX_LEN) begin
                                e_err = 1; e_code = 2'b01; m_phase = 0;
                            end else begin
                                m_len = int'(rx_dout); m_phase = 2;
                            end
                        end else if (m_phase == 2) begin
                            m_frame.push_back(rx_dout);
                            if (m_frame.size() == m_len) m_phase = 3;
                        end else begin
                            m_x = 8'(m_len);
                            foreach (m_frame[i]) m_x = m_x ^ m_frame[i];
                            if (m_x == rx_dout) begin
                                e_ok = 1; m_out = m_frame; m_phase = 4;
                            end else begin
                                e_err = 1; e_code = 2'b10; m_phase = 0;
                            end
                        end
                    end else if (s_tick) begin
                        m_ticks++;
                        if (m_ticks >= TMO) begin
                            e_err = 1; e_code = 2'b11; m_phase = 0;
                        end
                    end
                end
                4: begin
                    if (rx_done_tick) e_ovr = 1;
                    if (pkt_ready) begin
                        void'(m_out.pop_front());
                        if (m_out.size() == 0) m_phase = 0;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- monitors + per-cycle compare ----------------
    int         cyc = 0;
    int         n_ok = 0, n_err = 0, n_ovr = 0;
    logic [1:0] last_code = 0;
    logic [7:0] log_data[$];
    logic       log_last[$];
    int         log_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_pkt_valid", pkt_valid, 0);
            check("rst_pkt_data", pkt_data, 0);
            check("rst_pkt_last", pkt_last, 0);
            check("rst_frame_ok", frame_ok, 0);
            check("rst_frame_err", frame_err, 0);
            check("rst_err_code", err_code, 0);
            check("rst_rx_overrun", rx_overrun, 0);
            check("rst_busy", busy, 0);
        end else begin
            check("frame_ok", frame_ok, e_ok);
            check("frame_err", frame_err, e_err);
            check("err_code", err_code, e_code);
            check("rx_overrun", rx_overrun, e_ovr);
            check("busy", busy, m_phase != 0);
            check("pkt_valid", pkt_valid, m_phase == 4);
            if (m_phase == 4 && m_out.size() > 0) begin
                check("pkt_data", pkt_data, m_out[0]);
                check("pkt_last", pkt_last, m_out.size() == 1);
            end
        end
        if (frame_ok) n_ok++;
        if (frame_err) begin n_err++; last_code = err_code; end
        if (rx_overrun) n_ovr++;
        if (pkt_valid && pkt_ready) begin
            log_data.push_back(pkt_data);
            log_last.push_back(pkt_last);
            log_cyc.push_back(cyc);
        end
    end

    // ---------------- drivers ----------------
    int ready_mode = 0; // 0 always ready, 1 never ready, 2 random

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: pkt_ready = 1'b1;
            1: pkt_ready = 1'b0;
            default: pkt_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic drive(input logic done, input logic [7:0] b, input logic tick);
        @(posedge clk);
        #1;
        rx_done_tick = done;
        rx_dout = b;
        s_tick = tick;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        if (gap) begin
            drive(1'b1, b, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) drive(1'b0, 8'h00, 1'($urandom_range(0, 1)));
        end else begin
            drive(1'b1, b, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[$], input logic [7:0] chk, input bit gap);
        send_byte(8'hA5, gap);
        send_byte(len, gap);
        foreach (pl[i]) send_byte(pl[i], gap);
        send_byte(chk, gap);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            drive(1'b0, 8'h00, 1'b0);
            n++;
        end while (busy && n < 300);
        check("wait_idle_busy", busy, 0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic clear_mon();
        n_ok = 0; n_err = 0; n_ovr = 0;
        log_data.delete(); log_last.delete(); log_cyc.delete();
    endtask

    task automatic junk_byte(output logic [7:0] b);
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] pl[$];
        logic [7:0] b, x;
        int kind, len;

        reset_n = 1'b0;
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        reset_n = 1'b1;
        repeat (2) drive(1'b0, 8'h00, 1'b0);

        // good frame, always ready
        clear_mon();
        ready_mode = 0;
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h03, pl, 8'h03, 1'b0);
        wait_idle();
        check("good_ok_count", n_ok, 1);
        check("good_err_count", n_err, 0);
        check("good_len", log_data.size(), 3);
        if (log_data.size() == 3) begin
            check("good_b0", log_data[0], 8'h11);
            check("good_b1", log_data[1], 8'h22);
            check("good_b2", log_data[2], 8'h33);
            check("good_last", {log_last[0], log_last[1], log_last[2]}, 3'b001);
            check("good_consec01", log_cyc[1] - log_cyc[0], 1);
            check("good_consec12", log_cyc[2] - log_cyc[1], 1);
        end

        // bad checksum, then a good frame
        clear_mon();
        send_frame(8'h03, pl, 8'h04, 1'b0);
        wait_idle();
        check("badchk_err_count", n_err, 1);
        check("badchk_code", last_code, 2'b10);
        check("badchk_no_data", log_data.size(), 0);
        send_frame(8'h03, pl, 8'h03, 1'b1);
        wait_idle();
        check("after_badchk_ok", n_ok, 1);

        // length errors
        clear_mon();
        send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0);
        wait_idle();
        send_byte(8'hA5, 1'b0); send_byte(8'h11, 1'b0);
        wait_idle();
        check("len_err_count", n_err, 2);
        check("len_err_code", last_code, 2'b01);

        // timeout exactly on the terminal tick
        clear_mon();
        send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h11, 1'b0);
        for (int i = 1; i < TMO; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            drive(1'b0, 8'h00, 1'b0);
        end
        check("tmo_early", frame_err, 0);
        check("tmo_early_count", n_err, 0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("tmo_pulse", frame_err, 1);
        check("tmo_code", err_code, 2'b11);
        wait_idle();

        // byte on the terminal tick wins
        clear_mon();
        send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h11, 1'b0);
        for (int i = 1; i < TMO; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            drive(1'b0, 8'h00, 1'b0);
        end
        drive(1'b1, 8'h22, 1'b1);
        send_byte(8'h31, 1'b0);
        wait_idle();
        check("tmo_race_err", n_err, 0);
        check("tmo_race_ok", n_ok, 1);
        check("tmo_race_len", log_data.size(), 2);

        // back-pressure with an overrun byte
        clear_mon();
        ready_mode = 1;
        pl = '{8'h44, 8'h55};
        send_frame(8'h02, pl, 8'h13, 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h77, 1'b0);
        repeat (5) drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("bp_hold_data", pkt_data, 8'h44);
        check("bp_hold_valid", pkt_valid, 1);
        check("bp_overrun", n_ovr, 1);
        ready_mode = 0;
        wait_idle();
        check("bp_len", log_data.size(), 2);
        if (log_data.size() == 2) begin
            check("bp_b0", log_data[0], 8'h44);
            check("bp_b1", log_data[1], 8'h55);
            check("bp_last", log_last[1], 1);
        end

        // reset in the middle of the payload
        clear_mon();
        send_byte(8'hA5, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h11, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        reset_n = 1'b0;
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        reset_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        check("rst_no_pulses", n_ok + n_err + n_ovr, 0);
        pl = '{8'h5A};
        send_frame(8'h01, pl, 8'h5B, 1'b0);
        wait_idle();
        check("rst_next_ok", n_ok, 1);
        check("rst_next_len", log_data.size(), 1);

        // randomized traffic against the model
        ready_mode = 2;
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) begin
                junk_byte(b);
                send_byte(b, 1'b1);
            end
            kind = $urandom_range(0, 3);
            if (kind == 3) begin
                send_byte(8'hA5, 1'b1);
                b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
                send_byte(b, 1'b1);
            end else begin
                len = $urandom_range(1, MAX_LEN);
                pl.delete();
                x = 8'(len);
                for (int i = 0; i < len; i++) begin
                    b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
                    pl.push_back(b);
                    x = x ^ b;
                end
                if (kind == 2) x = x ^ 8'(1 << $urandom_range(0, 7));
                send_frame(8'(len), pl, x, 1'b1);
                if ($urandom_range(0, 2) == 0) begin
                    junk_byte(b);
                    send_byte(b, 1'b1);
                end
            end
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete, time %0t limit 900000", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
